led_driver: RTL and testbench



---
 rtl/led_driver.sv | 62 ++++++
 tb/tb_led_driver.sv | 139 +++++++++++++
 2 files changed

// File: rtl/led_driver.sv
// led_driver: registered RGB driver for four status LEDs, one of which can blink
// between its guess colour and its history colour.
module led_driver #(
    parameter int BLINK_HALF = 25000000,
    parameter int CNT_W      = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blink_enable,
    input  logic [1:0] blink_led,
    input  logic [2:0] guess_rgb0,
    input  logic [2:0] guess_rgb1,
    input  logic [2:0] guess_rgb2,
    input  logic [2:0] guess_rgb3,
    input  logic [2:0] history_rgb0,
    input  logic [2:0] history_rgb1,
    input  logic [2:0] history_rgb2,
    input  logic [2:0] history_rgb3,
    output logic [2:0] rgb0_out,
    output logic [2:0] rgb1_out,
    output logic [2:0] rgb2_out,
    output logic [2:0] rgb3_out
);
    typedef enum logic {SHOW_GUESS = 1'b0, SHOW_HISTORY = 1'b1} phase_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_HALF - 1);

    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wrap;
    logic [3:0][2:0]  guess, history, rgb, rgb_nxt;

    assign guess   = {guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0};
    assign history = {history_rgb3, history_rgb2, history_rgb1, history_rgb0};
    assign wrap    = cnt == LAST;

    // Disabling clears the counter so every blink starts with a full guess phase.
    always_comb begin
        cnt_nxt   = blink_enable ? (wrap ? '0 : cnt + CNT_W'(1)) : '0;
        phase_nxt = !blink_enable ? SHOW_GUESS : wrap ? phase_t'(~phase) : phase;
        rgb_nxt   = guess;
        for (int n = 0; n < 4; n++)
            rgb_nxt[n] = (blink_enable && blink_led == 2'(n) && phase == SHOW_HISTORY) ? history[n] : guess[n];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= SHOW_GUESS;
            rgb   <= '0;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
            rgb   <= rgb_nxt;
        end
    end

    assign rgb0_out = rgb[0];
    assign rgb1_out = rgb[1];
    assign rgb2_out = rgb[2];
    assign rgb3_out = rgb[3];
endmodule

// File: tb/tb_led_driver.sv
// tb_led_driver: directed scoreboard bench for led_driver (BLINK_HALF=4, plus a
// BLINK_HALF=1 instance for the every-cycle toggle case).
module tb_led_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic       blink_enable;
    logic [1:0] blink_led;
    logic [2:0] g [4];
    logic [2:0] h [4];
    logic [2:0] o0, o1, o2, o3;
    logic [2:0] f0, f1, f2, f3;

    typedef struct {
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    led_driver #(.BLINK_HALF(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .blink_enable(blink_enable), .blink_led(blink_led),
        .guess_rgb0(g[0]), .guess_rgb1(g[1]), .guess_rgb2(g[2]), .guess_rgb3(g[3]),
        .history_rgb0(h[0]), .history_rgb1(h[1]), .history_rgb2(h[2]), .history_rgb3(h[3]),
        .rgb0_out(o0), .rgb1_out(o1), .rgb2_out(o2), .rgb3_out(o3)
    );

    led_driver #(.BLINK_HALF(1), .CNT_W(1)) fast (
        .clk(clk), .rst(rst), .blink_enable(blink_enable), .blink_led(blink_led),
        .guess_rgb0(g[0]), .guess_rgb1(g[1]), .guess_rgb2(g[2]), .guess_rgb3(g[3]),
        .history_rgb0(h[0]), .history_rgb1(h[1]), .history_rgb2(h[2]), .history_rgb3(h[3]),
        .rgb0_out(f0), .rgb1_out(f1), .rgb2_out(f2), .rgb3_out(f3)
    );

    // Expected display: guess colours everywhere except LED hl (-1 = none) showing history.
    function automatic logic [11:0] mk(input int hl);
        logic [11:0] r;
        r = '0;
        for (int n = 0; n < 4; n++)
            r[n*3 +: 3] = (n == hl) ? h[n] : g[n];
        return r;
    endfunction

    task automatic tick(input logic [11:0] e, input string tag);
        exp_t x;
        x.v   = e;
        x.tag = tag;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        total++;
        assert ({o3, o2, o1, o0} === x.v)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", x.tag, {o3, o2, o1, o0}, x.v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        blink_enable = 1'b0;
        blink_led    = 2'd1;
        for (int n = 0; n < 4; n++) g[n] = 3'b001;
        h[0] = 3'b100;
        h[1] = 3'b010;
        h[2] = 3'b011;
        h[3] = 3'b110;

        tick(12'h000, "rst_a");
        tick(12'h000, "rst_b");
        rst = 1'b0;
        tick(mk(-1), "rst_release");

        for (int i = 0; i < 40; i++) tick(mk(-1), "steady");

        // Cadence: guess 1-4, history 5-8, guess 9-12; the fast instance flips every edge.
        blink_enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick(mk((i >= 5 && i <= 8) ? 1 : -1), "cadence");
            total++;
            assert (f1 === ((i % 2 == 0) ? h[1] : g[1]))
            else begin
                bad++;
                $error("FAIL half1 cycle=%0d got=%b exp=%b", i, f1, (i % 2 == 0) ? h[1] : g[1]);
            end
        end

        tick(mk(1), "hist_before_retarget");
        blink_led = 2'd3;
        tick(mk(3), "retarget");
        tick(mk(3), "retarget_hold_a");
        tick(mk(3), "retarget_hold_b");
        for (int i = 17; i <= 20; i++) tick(mk(-1), "post_retarget_guess");
        tick(mk(3), "post_retarget_hist");

        blink_enable = 1'b0;
        tick(mk(-1), "disable_mid_phase");
        tick(mk(-1), "disabled");
        blink_enable = 1'b1;
        for (int i = 0; i < 4; i++) tick(mk(-1), "reenable_guess");
        tick(mk(3), "reenable_hist");

        blink_enable = 1'b0;
        tick(mk(-1), "idle");
        g[2] = 3'b111;
        #1;
        total++;
        assert (o2 === 3'b001)
        else begin
            bad++;
            $error("FAIL no_comb_path got=%b exp=%b", o2, 3'b001);
        end
        tick({g[3], 3'b111, g[1], g[0]}, "latency_g2");
        tick(mk(-1), "latency_hold");

        blink_enable = 1'b1;
        blink_led    = 2'd0;
        for (int i = 0; i < 4; i++) tick(mk(-1), "led0_guess");
        tick(mk(0), "led0_hist");
        rst = 1'b1;
        tick(12'h000, "rst_mid_blink");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick(mk(-1), "after_rst_guess");
        tick(mk(0), "after_rst_hist");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
